// File: rtl/keypad_pkg.sv
// keypad_pkg: shared constants for the 4x4 hex keypad scanner.
//   - debounce FSM state encodings (plain localparams for legacy tools)
//   - key map, indexed by row*4 + col (PmodKYPD layout)
//   - active-low row strobe patterns, indexed by row
package keypad_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_CONFIRM = 2'd1;
  localparam state_t ST_PRESSED = 2'd2;
  localparam state_t ST_RELEASE = 2'd3;

  // Entry 0 is row 0 / col 0 ("1"); entry 15 is row 3 / col 3 ("D").
  localparam logic [15:0][3:0] KEY_MAP = {
    4'hD, 4'hE, 4'hF, 4'h0,
    4'hC, 4'h9, 4'h8, 4'h7,
    4'hB, 4'h6, 4'h5, 4'h4,
    4'hA, 4'h3, 4'h2, 4'h1
  };

  // row_out[3] strobes row 0, so row 0 drives 4'b0111.
  localparam logic [3:0][3:0] ROW_STROBE = {
    4'b1110, 4'b1101, 4'b1011, 4'b0111
  };

endpackage

// File: rtl/keypad_row_scan.sv
// keypad_row_scan: row sequencer for the keypad scanner.
// Each row is driven for SCAN_DIV clocks; the last dwell cycle is the
// column sample point, and the sample of row 3 closes a full scan.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   row_out   - active-low one-hot row strobe
//   row_idx   - index of the row currently driven
//   sample    - high on the last dwell cycle of the current row
//   scan_end  - high on the sample cycle of row 3
module keypad_row_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] row_out,
  output logic [1:0] row_idx,
  output logic       sample,
  output logic       scan_end
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] dwell_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      dwell_cnt <= '0;
      row_idx   <= 2'd0;
    end else if (sample) begin
      dwell_cnt <= '0;
      row_idx   <= row_idx + 2'd1;
    end else begin
      dwell_cnt <= dwell_cnt + 1'b1;
    end
  end

  assign sample   = (dwell_cnt == CNT_LAST);
  assign scan_end = sample && (row_idx == 2'd3);
  assign row_out  = ROW_STROBE[row_idx];

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 hex keypad, decodes a single pressed key and
// debounces presses and releases over whole scans.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   col_in     - active-low column returns, col_in[0] = leftmost column
//   row_out    - active-low row strobes, row_out[3] = top row
//   key_code   - last accepted key code (held through release)
//   key_valid  - one-cycle pulse per accepted press
//   key_held   - high while the accepted key is still considered pressed
// Build option: define KEYPAD_REPEAT_EN to add auto-repeat pulses every
// REPEAT_SCANS scans while a key stays pressed.
//
// state      | meaning
// -----------+-------------------------------------------------------
// ST_IDLE    | no key accepted, no candidate
// ST_CONFIRM | candidate seen on 'match' consecutive single-key scans
// ST_PRESSED | key accepted and still present
// ST_RELEASE | accepted key missing for 'match' consecutive scans
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_SCANS   = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col_in,
  output logic [3:0] row_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int MATCH_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [MATCH_W-1:0] MATCH_ONE = MATCH_W'(1);
  localparam logic [MATCH_W-1:0] MATCH_MAX = MATCH_W'(DEBOUNCE_SCANS);

  logic [1:0]  row_idx;
  logic        sample;
  logic        scan_end;

  keypad_row_scan #(.SCAN_DIV(SCAN_DIV)) u_row_scan (
    .clk      (clk),
    .rst      (rst),
    .row_out  (row_out),
    .row_idx  (row_idx),
    .sample   (sample),
    .scan_end (scan_end)
  );

  logic [15:0]        scan_bits;
  logic [15:0]        scan_now;
  logic [3:0]         hit_idx;
  logic [3:0]         hit_code;
  logic               is_single;
  logic               same_key;
  state_t             state;
  logic [3:0]         cand;
  logic [MATCH_W-1:0] match;
  logic [MATCH_W-1:0] match_inc;
  logic [MATCH_W-1:0] match_next;
  logic               match_done;

  // Current row's pressed keys merged over the stored scan, so the row 3
  // sample is visible in the same cycle the scan is classified.
  always_comb begin
    scan_now = scan_bits;
    scan_now[{row_idx, 2'b00} +: 4] = ~col_in;
  end

  always_comb begin
    hit_idx = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (scan_now[i]) hit_idx = 4'(i);
    end
  end

  // Exactly one bit set; MULTI and NONE both fall out as "not single".
  assign is_single = (scan_now != 16'h0) && ((scan_now & (scan_now - 16'd1)) == 16'h0);
  assign hit_code  = KEY_MAP[hit_idx];
  assign same_key  = is_single && (hit_code == cand);

  assign match_inc  = (match == MATCH_MAX) ? match : match + 1'b1;
  // A run continues only in CONFIRM (same key) or RELEASE (still missing);
  // every other transition starts a fresh run of one scan.
  assign match_next = ((state == ST_CONFIRM && same_key) || (state == ST_RELEASE && !same_key))
                      ? match_inc : MATCH_ONE;
  assign match_done = (match_next == MATCH_MAX);

`ifdef KEYPAD_REPEAT_EN
  localparam int REP_W = $clog2(REPEAT_SCANS + 1);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_SCANS - 1);

  logic [REP_W-1:0] rep_cnt;
  logic             rep_fire;

  assign rep_fire = scan_end && (state == ST_PRESSED) && same_key && (rep_cnt == REP_LAST);

  // Held at zero outside PRESSED, so it is already clear on entry.
  always_ff @(posedge clk) begin
    if (rst || state != ST_PRESSED) begin
      rep_cnt <= '0;
    end else if (scan_end && same_key) begin
      rep_cnt <= rep_fire ? '0 : rep_cnt + 1'b1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_bits <= 16'h0;
      state     <= ST_IDLE;
      cand      <= 4'h0;
      match     <= '0;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (sample) scan_bits <= scan_now;
      if (scan_end) begin
        case (state)
          ST_IDLE, ST_CONFIRM: begin
            if (is_single) begin
              cand <= hit_code;
              if (match_done) begin
                state     <= ST_PRESSED;
                key_code  <= hit_code;
                key_valid <= 1'b1;
                match     <= '0;
              end else begin
                state <= ST_CONFIRM;
                match <= match_next;
              end
            end else begin
              state <= ST_IDLE;
              match <= '0;
            end
          end
          ST_PRESSED: begin
            if (!same_key) begin
              if (match_done) begin
                state <= ST_IDLE;
                match <= '0;
              end else begin
                state <= ST_RELEASE;
                match <= match_next;
              end
            end
          end
          ST_RELEASE: begin
            if (same_key) begin
              state <= ST_PRESSED;
              match <= '0;
            end else if (match_done) begin
              state <= ST_IDLE;
              match <= '0;
            end else begin
              match <= match_next;
            end
          end
          default: begin
            state <= ST_IDLE;
            match <= '0;
          end
        endcase
`ifdef KEYPAD_REPEAT_EN
        if (rep_fire) key_valid <= 1'b1;
`endif
      end
    end
  end

  assign key_held = (state == ST_PRESSED) || (state == ST_RELEASE);

endmodule

// File: tb/tb_keypad_scanner.sv
module tb_keypad_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 3;
  localparam int REP      = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] col_in;
  logic [3:0] row_out;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  // Pressed-key matrix, bit r*4+c.
  logic [15:0] keys = 16'h0;

  keypad_scanner #(
    .SCAN_DIV       (SCAN_DIV),
    .DEBOUNCE_SCANS (DEB),
    .REPEAT_SCANS   (REP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .col_in    (col_in),
    .row_out   (row_out),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  always #5 clk = ~clk;

  // Physical keypad: a pressed key pulls its column low when its row is driven.
  always_comb begin
    col_in = 4'hF;
    for (int r = 0; r < 4; r++) begin
      if (!row_out[3-r]) col_in = col_in & ~keys[r*4 +: 4];
    end
  end

  int checks = 0;
  int errors = 0;

  int kmap[16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 0, 15, 14, 13};

  // Reference model: tracks runs of identical single-key scans and runs of
  // scans missing the held key.
  int m_n;
  bit m_hold;
  int m_run;
  int m_cand;
  int m_code;
  int m_miss;
  int m_rep;
  bit m_valid;

  logic [9:0] obs_q[$];
  logic [9:0] exp_q[$];
  int         pulse_q[$];

  task automatic model_reset();
    m_n = 0; m_hold = 0; m_run = 0; m_cand = 0; m_code = 0;
    m_miss = 0; m_rep = 0; m_valid = 0;
  endtask

  task automatic model_scan();
    int cnt;
    int idx;
    int k;
    bit single;
    cnt = $countones(keys);
    idx = 0;
    for (int i = 0; i < 16; i++) if (keys[i]) idx = i;
    single = (cnt == 1);
    k = kmap[idx];
    if (!m_hold) begin
      if (single) begin
        if (m_run > 0 && k == m_cand) m_run++;
        else begin m_run = 1; m_cand = k; end
        if (m_run == DEB) begin
          m_hold = 1; m_code = k; m_valid = 1; m_miss = 0; m_rep = 0; m_run = 0;
        end
      end else begin
        m_run = 0;
      end
    end else begin
      if (single && k == m_code) begin
        if (m_miss > 0) begin
          m_miss = 0; m_rep = 0;
        end else begin
          m_rep++;
`ifdef KEYPAD_REPEAT_EN
          if (m_rep == REP) begin m_valid = 1; m_rep = 0; end
`endif
        end
      end else begin
        m_miss++;
        if (m_miss == DEB) begin m_hold = 0; m_run = 0; end
      end
    end
  endtask

  function automatic logic [3:0] exp_row(int n);
    logic [3:0] one_hot;
    one_hot = 4'b1000 >> ((n / 4) % 4);
    return ~one_hot;
  endfunction

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      m_n++;
      m_valid = 0;
      if (m_n % 16 == 0) model_scan();
    end
    #1;
    obs_q.push_back({row_out, key_code, key_valid, key_held});
    exp_q.push_back({exp_row(m_n), 4'(m_code), m_valid, m_hold});
    if (key_valid === 1'b1) pulse_q.push_back(m_n);
  endtask

  task automatic scans(input logic [15:0] mask, input int count);
    keys = mask;
    repeat (count * 16) tick();
  endtask

  task automatic clear_logs();
    obs_q.delete();
    exp_q.delete();
    pulse_q.delete();
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    clear_logs();
  endtask

  task automatic test_reset();
    logic [3:0] pat[4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
    int nbad;
    int first;
    keys = 16'h0;
    apply_reset();
    checks++;
    if ({row_out, key_code, key_valid, key_held} !== 10'b0111_0000_0_0) begin
      errors++;
      $display("FAIL reset_values: got row=%b code=%h valid=%b held=%b want row=0111 code=0 valid=0 held=0",
               row_out, key_code, key_valid, key_held);
    end
    scans(16'h0, 2);
    nbad = 0; first = 0;
    for (int i = 0; i < obs_q.size(); i++) begin
      if (obs_q[i][9:6] !== pat[((i + 1) / 4) % 4]) begin
        if (nbad == 0) first = i;
        nbad++;
      end
    end
    checks++;
    if (nbad != 0) begin
      errors++;
      $display("FAIL row_sequence: %0d cycles wrong, first cycle %0d got %b want %b",
               nbad, first, obs_q[first][9:6], pat[((first + 1) / 4) % 4]);
    end
    checks++;
    if (pulse_q.size() != 0) begin
      errors++;
      $display("FAIL idle_no_pulse: got %0d pulses want 0", pulse_q.size());
    end
    nbad = 0; first = 0;
    for (int i = 0; i < obs_q.size(); i++) if (obs_q[i] !== exp_q[i]) begin
      if (nbad == 0) first = i;
      nbad++;
    end
    checks++;
    if (nbad != 0) begin
      errors++;
      $display("FAIL reset_trace: %0d cycles differ, first %0d got %h want %h", nbad, first, obs_q[first], exp_q[first]);
    end
  endtask

  task automatic test_single_press();
    int nbad;
    int first;
    apply_reset();
    scans(16'h0040, 5);
    checks++;
    if (pulse_q.size() != 1) begin
      errors++;
      $display("FAIL press_pulse_count: got %0d want 1", pulse_q.size());
    end else begin
      checks++;
      if (pulse_q[0] != 48) begin
        errors++;
        $display("FAIL press_pulse_time: got cycle %0d want 48", pulse_q[0]);
      end
    end
    checks++;
    if ({key_code, key_held} !== {4'h6, 1'b1}) begin
      errors++;
      $display("FAIL press_code_held: got code=%h held=%b want code=6 held=1", key_code, key_held);
    end
    scans(16'h0, 2);
    checks++;
    if (key_held !== 1'b1) begin
      errors++;
      $display("FAIL release_early: got held=%b want 1 after 2 empty scans", key_held);
    end
    scans(16'h0, 1);
    checks++;
    if ({key_code, key_held} !== {4'h6, 1'b0}) begin
      errors++;
      $display("FAIL release_done: got code=%h held=%b want code=6 held=0", key_code, key_held);
    end
    nbad = 0; first = 0;
    for (int i = 0; i < obs_q.size(); i++) if (obs_q[i] !== exp_q[i]) begin
      if (nbad == 0) first = i;
      nbad++;
    end
    checks++;
    if (nbad != 0) begin
      errors++;
      $display("FAIL press_trace: %0d cycles differ, first %0d got %h want %h", nbad, first, obs_q[first], exp_q[first]);
    end
  endtask

  task automatic test_bounce();
    int nbad;
    int first;
    clear_logs();
    scans(16'h0400, 1);
    scans(16'h0000, 1);
    scans(16'h0400, 1);
    scans(16'h0000, 1);
    checks++;
    if (pulse_q.size() != 0 || key_held !== 1'b0) begin
      errors++;
      $display("FAIL bounce_reject: got %0d pulses held=%b want 0 pulses held=0", pulse_q.size(), key_held);
    end
    // Only a fresh run of three scans may accept, proving the count restarted.
    scans(16'h0400, 2);
    checks++;
    if (pulse_q.size() != 0) begin
      errors++;
      $display("FAIL bounce_stale_count: got %0d pulses want 0", pulse_q.size());
    end
    scans(16'h0400, 1);
    checks++;
    if (pulse_q.size() != 1 || key_code !== 4'h9) begin
      errors++;
      $display("FAIL bounce_accept: got %0d pulses code=%h want 1 pulse code=9", pulse_q.size(), key_code);
    end
    scans(16'h0, 3);
    nbad = 0; first = 0;
    for (int i = 0; i < obs_q.size(); i++) if (obs_q[i] !== exp_q[i]) begin
      if (nbad == 0) first = i;
      nbad++;
    end
    checks++;
    if (nbad != 0) begin
      errors++;
      $display("FAIL bounce_trace: %0d cycles differ, first %0d got %h want %h", nbad, first, obs_q[first], exp_q[first]);
    end
  endtask

  task automatic test_multi();
    int nbad;
    int first;
    clear_logs();
    scans(16'h8001, 6);
    checks++;
    if (pulse_q.size() != 0 || key_code !== 4'h9 || key_held !== 1'b0) begin
      errors++;
      $display("FAIL multi_reject: got %0d pulses code=%h held=%b want 0 pulses code=9 held=0",
               pulse_q.size(), key_code, key_held);
    end
    scans(16'h0, 1);
    nbad = 0; first = 0;
    for (int i = 0; i < obs_q.size(); i++) if (obs_q[i] !== exp_q[i]) begin
      if (nbad == 0) first = i;
      nbad++;
    end
    checks++;
    if (nbad != 0) begin
      errors++;
      $display("FAIL multi_trace: %0d cycles differ, first %0d got %h want %h", nbad, first, obs_q[first], exp_q[first]);
    end
  endtask

  task automatic test_reset_mid_confirm();
    int nbad;
    int first;
    clear_logs();
    scans(16'h0008, 2);
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({row_out, key_code, key_valid, key_held} !== 10'b0111_0000_0_0) begin
      errors++;
      $display("FAIL midreset_values: got row=%b code=%h valid=%b held=%b want row=0111 code=0 valid=0 held=0",
               row_out, key_code, key_valid, key_held);
    end
    clear_logs();
    scans(16'h0008, 2);
    checks++;
    if (pulse_q.size() != 0) begin
      errors++;
      $display("FAIL midreset_early: got %0d pulses want 0 after 2 scans", pulse_q.size());
    end
    scans(16'h0008, 1);
    checks++;
    if (pulse_q.size() != 1 || key_code !== 4'hA) begin
      errors++;
      $display("FAIL midreset_accept: got %0d pulses code=%h want 1 pulse code=a", pulse_q.size(), key_code);
    end else begin
      checks++;
      if (pulse_q[0] != 48) begin
        errors++;
        $display("FAIL midreset_time: got cycle %0d want 48", pulse_q[0]);
      end
    end
    scans(16'h0, 3);
    nbad = 0; first = 0;
    for (int i = 0; i < obs_q.size(); i++) if (obs_q[i] !== exp_q[i]) begin
      if (nbad == 0) first = i;
      nbad++;
    end
    checks++;
    if (nbad != 0) begin
      errors++;
      $display("FAIL midreset_trace: %0d cycles differ, first %0d got %h want %h", nbad, first, obs_q[first], exp_q[first]);
    end
  endtask

  task automatic test_random();
    logic [15:0] mask;
    int r;
    int a;
    int b;
    int nbad;
    int first;
    mask = 16'h0;
    clear_logs();
    for (int i = 0; i < 30; i++) begin
      r = $urandom_range(0, 9);
      if (r < 2) begin
        mask = 16'h0;
      end else if (r < 7) begin
        if (mask == 16'h0) mask = 16'h1 << $urandom_range(0, 15);
      end else if (r < 9) begin
        mask = 16'h1 << $urandom_range(0, 15);
      end else begin
        a = $urandom_range(0, 15);
        b = (a + $urandom_range(1, 15)) % 16;
        mask = (16'h1 << a) | (16'h1 << b);
      end
      scans(mask, $urandom_range(1, 5));
    end
    nbad = 0; first = 0;
    for (int i = 0; i < obs_q.size(); i++) if (obs_q[i] !== exp_q[i]) begin
      if (nbad == 0) first = i;
      nbad++;
    end
    checks++;
    if (nbad != 0) begin
      errors++;
      $display("FAIL random_trace: %0d cycles differ, first %0d got %h want %h", nbad, first, obs_q[first], exp_q[first]);
    end
    checks++;
    if (key_code !== 4'(m_code)) begin
      errors++;
      $display("FAIL random_code: got %h want %h", key_code, 4'(m_code));
    end
  endtask

  task automatic test_hold_long();
`ifdef KEYPAD_REPEAT_EN
    int want[$] = '{48, 80, 112, 144};
`else
    int want[$] = '{48};
`endif
    int nbad;
    int first;
    apply_reset();
    scans(16'h1000, 9);
    checks++;
    if (pulse_q.size() != want.size()) begin
      errors++;
      $display("FAIL hold_pulse_count: got %0d want %0d", pulse_q.size(), want.size());
    end else begin
      for (int i = 0; i < want.size(); i++) begin
        checks++;
        if (pulse_q[i] != want[i]) begin
          errors++;
          $display("FAIL hold_pulse_time[%0d]: got cycle %0d want %0d", i, pulse_q[i], want[i]);
        end
      end
    end
    checks++;
    if ({key_code, key_held} !== {4'h0, 1'b1}) begin
      errors++;
      $display("FAIL hold_code: got code=%h held=%b want code=0 held=1", key_code, key_held);
    end
    nbad = 0; first = 0;
    for (int i = 0; i < obs_q.size(); i++) if (obs_q[i] !== exp_q[i]) begin
      if (nbad == 0) first = i;
      nbad++;
    end
    checks++;
    if (nbad != 0) begin
      errors++;
      $display("FAIL hold_trace: %0d cycles differ, first %0d got %h want %h", nbad, first, obs_q[first], exp_q[first]);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_press();
    test_bounce();
    test_multi();
    test_reset_mid_confirm();
    test_random();
    test_hold_long();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
